// File: rtl/operand_entry_adder_if.sv
// ---------------------------------------------------------------------------
// operand_entry_adder_if
//   Keypad-to-adder bus. Bundles the decoded key strobe and the display-side
//   results of operand_entry_adder so the block can be dropped between the
//   keypad decoder and the display multiplexer with a single connection.
//
//   Signals
//     key_valid    : high while a decoded key is present (sync to clk)
//     key_code     : 0x0-0x9 digit, 0xA ADD, 0xB EQUALS, 0xC CLEAR, 0xD-0xF unused
//     sum_result   : binary value to display (operand being entered, or sum)
//     result_valid : high while sum_result holds a completed sum
//     entry_state  : 00 ENTRY_A, 01 ENTRY_B, 10 SHOW_SUM
//
//   Modports
//     master : keypad / display side (drives keys, observes results)
//     slave  : the adder itself
// ---------------------------------------------------------------------------
interface operand_entry_adder_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [13:0] sum_result;
  logic        result_valid;
  logic [1:0]  entry_state;

  modport master (
    output key_valid,
    output key_code,
    input  sum_result,
    input  result_valid,
    input  entry_state
  );

  modport slave (
    input  key_valid,
    input  key_code,
    output sum_result,
    output result_valid,
    output entry_state
  );
endinterface

// File: rtl/operand_entry_adder.sv
// ---------------------------------------------------------------------------
// operand_entry_adder
//   Two-operand decimal entry calculator. Digits build operand A, ADD moves
//   to operand B, EQUALS shows A+B. Each operand holds at most three digits
//   (0-999). Keys are accepted once per rising edge of key_valid.
//
//   Ports
//     clk   : system clock, rising-edge active
//     reset : asynchronous, active-high; returns to ENTRY_A with all data 0
//     bus   : operand_entry_adder_if.slave
//             key_valid/key_code in, sum_result/result_valid/entry_state out
//
//   All outputs are decoded from registers only; an accepted key is visible
//   on the outputs from the cycle after the edge that accepts it.
// ---------------------------------------------------------------------------
module operand_entry_adder (
  input  logic                  clk,
  input  logic                  reset,
  operand_entry_adder_if.slave  bus
);

  localparam logic [1:0] ENTRY_A  = 2'b00;
  localparam logic [1:0] ENTRY_B  = 2'b01;
  localparam logic [1:0] SHOW_SUM = 2'b10;

  localparam logic [3:0] KEY_ADD    = 4'hA;
  localparam logic [3:0] KEY_EQUALS = 4'hB;
  localparam logic [3:0] KEY_CLEAR  = 4'hC;

  localparam logic [1:0] MAX_DIGITS = 2'd3;

  // State registers
  logic [1:0]  state;
  logic [9:0]  operand_a;
  logic [9:0]  operand_b;
  logic [1:0]  digit_count;
  logic [13:0] sum_reg;
  logic        key_prev;

  // Next-state values
  logic [1:0]  state_nxt;
  logic [9:0]  operand_a_nxt;
  logic [9:0]  operand_b_nxt;
  logic [1:0]  digit_count_nxt;
  logic [13:0] sum_reg_nxt;

  // Decode helpers
  logic        key_accept;
  logic        is_digit;
  logic        in_entry;
  logic [9:0]  active_operand;
  logic [9:0]  shifted_operand;

  // A key counts only on the cycle key_valid rises; key_prev resets to 0 so
  // a key already held when reset releases is taken at the first edge.
  assign key_accept = bus.key_valid & ~key_prev;
  assign is_digit   = (bus.key_code <= 4'd9);
  assign in_entry   = (state == ENTRY_A) || (state == ENTRY_B);

  assign active_operand = (state == ENTRY_B) ? operand_b : operand_a;

  // operand*10 + digit; digit_count < 3 bounds the result to 999, so the
  // 10-bit arithmetic never wraps when it is actually used.
  assign shifted_operand = (active_operand * 10'd10) + {6'd0, bus.key_code};

  always_comb begin
    state_nxt       = state;
    operand_a_nxt   = operand_a;
    operand_b_nxt   = operand_b;
    digit_count_nxt = digit_count;
    sum_reg_nxt     = sum_reg;

    if (key_accept) begin
      if (is_digit) begin
        if (state == SHOW_SUM) begin
          // A digit after a result begins a fresh calculation with it.
          state_nxt       = ENTRY_A;
          operand_a_nxt   = {6'd0, bus.key_code};
          operand_b_nxt   = '0;
          digit_count_nxt = 2'd1;
          sum_reg_nxt     = '0;
        end else if (in_entry && (digit_count != MAX_DIGITS)) begin
          if (state == ENTRY_A) begin
            operand_a_nxt = shifted_operand;
          end else begin
            operand_b_nxt = shifted_operand;
          end
          digit_count_nxt = digit_count + 2'd1;
        end
      end else begin
        case (bus.key_code)
          KEY_ADD: begin
            if (state == ENTRY_A) begin
              state_nxt       = ENTRY_B;
              operand_b_nxt   = '0;
              digit_count_nxt = '0;
            end
          end
          KEY_EQUALS: begin
            if (state == ENTRY_B) begin
              state_nxt   = SHOW_SUM;
              sum_reg_nxt = {4'd0, operand_a} + {4'd0, operand_b};
            end
          end
          KEY_CLEAR: begin
            state_nxt       = ENTRY_A;
            operand_a_nxt   = '0;
            operand_b_nxt   = '0;
            digit_count_nxt = '0;
            sum_reg_nxt     = '0;
          end
          default: begin
            // 0xD-0xF: no effect
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ENTRY_A;
      operand_a   <= '0;
      operand_b   <= '0;
      digit_count <= '0;
      sum_reg     <= '0;
      key_prev    <= 1'b0;
    end else begin
      state       <= state_nxt;
      operand_a   <= operand_a_nxt;
      operand_b   <= operand_b_nxt;
      digit_count <= digit_count_nxt;
      sum_reg     <= sum_reg_nxt;
      key_prev    <= bus.key_valid;
    end
  end

  // Display selection from registered values only.
  always_comb begin
    case (state)
      ENTRY_A:  bus.sum_result = {4'd0, operand_a};
      ENTRY_B:  bus.sum_result = {4'd0, operand_b};
      SHOW_SUM: bus.sum_result = sum_reg;
      default:  bus.sum_result = '0;
    endcase
  end

  assign bus.result_valid = (state == SHOW_SUM);
  assign bus.entry_state  = state;

endmodule

// File: doc/operand_entry_adder.md
OPERAND_ENTRY_ADDER -- requirements
Module: operand_entry_adder

Interface
REQ-001 The block SHALL expose `clk`, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-002 The block SHALL expose `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL expose `key_valid`, input, 1 bit: high while a decoded keypad key is present; synchronous to `clk`.
REQ-004 The block SHALL expose `key_code`, input, 4 bits: key value (0x0-0x9 digits, 0xA ADD, 0xB EQUALS, 0xC CLEAR, 0xD-0xF unused); stable while `key_valid` is high.
REQ-005 The block SHALL expose `sum_result`, output, 14 bits: binary value to display (operand being entered, or the sum); feeds the display multiplexer directly.
REQ-006 The block SHALL expose `result_valid`, output, 1 bit: high while `sum_result` holds a completed sum.
REQ-007 The block SHALL expose `entry_state`, output, 2 bits: 00 ENTRY_A, 01 ENTRY_B, 10 SHOW_SUM; 11 never driven.

Function
REQ-008 Key acceptance SHALL occur only on the rising edge of `key_valid`, defined as `key_valid`=1 this cycle and 0 in the previous cycle (registered copy); a held key is accepted exactly once.
REQ-009 An accepted key SHALL update state and all outputs at that same clock edge; outputs reflect it from the following cycle (1-cycle latency), with no combinational input-to-output path.
REQ-010 Registers SHALL be: `operand_a` [9:0], `operand_b` [9:0], `digit_count` [1:0], `sum_reg` [13:0], state.
REQ-011 Digit key in ENTRY_A or ENTRY_B with `digit_count` < 3: the active operand becomes operand*10 + digit and `digit_count` is incremented; a leading 0 counts as a digit.
REQ-012 Digit key with `digit_count` = 3 SHALL be ignored, leaving the operand unchanged; operands are therefore limited to 0-999.
REQ-013 ADD in ENTRY_A SHALL transition to ENTRY_B, clearing `operand_b` and `digit_count`; ADD with zero digits entered is legal (A=0).
REQ-014 ADD in ENTRY_B or SHOW_SUM SHALL be ignored.
REQ-015 EQUALS in ENTRY_B SHALL load `sum_reg` with `operand_a` + `operand_b` (zero-extended to 14 bits, max 1998, no overflow possible) and transition to SHOW_SUM.
REQ-016 EQUALS in ENTRY_A or SHOW_SUM SHALL be ignored.
REQ-017 CLEAR in any state SHALL zero `operand_a`, `operand_b`, `digit_count` and `sum_reg`, and transition to ENTRY_A.
REQ-018 A digit key in SHOW_SUM SHALL start a new calculation: `operand_a` is set to the digit, `digit_count` to 1, `operand_b` and `sum_reg` to 0, and the state to ENTRY_A.
REQ-019 Keys 0xD-0xF SHALL be ignored in every state, with no register change.
REQ-020 `sum_result` SHALL equal `operand_a` in ENTRY_A, `operand_b` in ENTRY_B, and `sum_reg` in SHOW_SUM, zero-extended; it SHALL be driven from registers only.
REQ-021 `result_valid` SHALL be 1 exactly when the state is SHOW_SUM.
REQ-022 `key_valid` low SHALL cause no state change.

Reset
REQ-023 On `reset` high, asynchronously: state becomes ENTRY_A, all operand/count/sum registers become 0, and the key-edge register becomes 0.
REQ-024 During and after reset, `sum_result` SHALL be 0, `result_valid` 0, and `entry_state` 00.
REQ-025 Reset asserted mid-entry or in SHOW_SUM SHALL discard all data.
REQ-026 If `key_valid` is already high when reset deasserts, it SHALL be accepted at the first clock edge after deassertion, because the edge register reset value is 0.

Verification
REQ-027 Keys 1,2,3,ADD,4,5,EQUALS -> `sum_result` shows 1, 12, 123, 0, 4, 45, then 168; `result_valid`=1; `entry_state`=10.
REQ-028 Keys 9,9,9,9,ADD,9,9,9,EQUALS -> the fourth 9 is ignored (display stays 999); final `sum_result`=1998.
REQ-029 `key_valid` held high 50 cycles with code 0x7 -> `operand_a`=7, `digit_count`=1 (accepted once).
REQ-030 Sequence 5,ADD,5,EQUALS (display 10) then key 3 -> `sum_result`=3, `result_valid`=0, `entry_state`=00; then CLEAR -> `sum_result`=0.
REQ-031 EQUALS in ENTRY_A, ADD in ENTRY_B, and keys 0xD/0xE -> no change to any output.
REQ-032 `reset` pulsed asynchronously (between clock edges) while in ENTRY_B with operand_b=42 -> outputs become 0/0/00 immediately, without waiting for a clock edge.
